shifter_operand_fetch: RTL and testbench
========================================

# shifter_operand_fetch

Upstream feeder for the barrel shifter. Takes one data-processing instruction per handshake and decodes its shifter-operand addressing mode: 32-bit immediate, immediate shift, or register shift. Reads Rm and Rs through a single synchronous register-file read port. Presents a registered, held-until-accepted bundle {data, shift value, op select, carry} that drives the shifter inputs directly.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction available
- in_ready  out  1  block can accept an instruction
- in_instr  in  32  data-processing instruction; uses bits [25], [11:0]
- in_carry  in  1  current CPSR C flag
- in_flush  in  1  synchronous pipeline flush
- rf_rd_en  out  1  register-file read request
- rf_rd_addr  out  4  register index; 0 when rf_rd_en=0
- rf_rd_data  in  32  read data, valid the cycle after rf_rd_en
- out_valid  out  1  operand bundle valid
- out_ready  in  1  downstream accepts bundle
- out_data  out  32  value to shift
- out_shift_value  out  8  shift amount
- out_op_select  out  3  LSL=0, LSR=1, ASR=2, ROR=3, RRX=4 (zero-extend when wiring to the shifter)
- out_carry  out  1  carry-in for the shifter

## Operation
- States: IDLE, RD_RM, RD_RS, CAP, OUT.
- IDLE: in_ready=1.
  - On in_valid, latch in_instr and in_carry.
  - If I (bit25)=1, go to OUT. Otherwise go to RD_RM.
- Immediate (I=1):
  - out_data={24'b0, instr[7:0]}
  - out_op_select=ROR
  - out_shift_value={3'b0, instr[11:8], 1'b0}
  - rot=0 gives shift 0, so the shifter passes the carry through.
- RD_RM: rf_rd_en=1, rf_rd_addr=instr[3:0].
  - If instr[4]=1, go to RD_RS. Otherwise go to CAP.
- RD_RS: capture rf_rd_data into out_data. Drive rf_rd_en=1, rf_rd_addr=instr[11:8]. Go to CAP.
- CAP: capture rf_rd_data, then go to OUT.
  - Immediate shift (instr[4]=0): rf_rd_data goes to out_data.
  - Register shift: rf_rd_data[7:0] goes to out_shift_value, and out_op_select=instr[6:5].
- Immediate shift amount (amt=instr[11:7], type=instr[6:5]):
  - LSL: shift=amt; amt=0 gives shift 0.
  - LSR/ASR: shift=amt; amt=0 gives shift 32 (8'd32).
  - ROR: shift=amt; amt=0 gives op=RRX with shift=1. The shift value is never 0 for RRX.
- OUT: out_valid=1, all out_* held stable. When out_ready=1, go to IDLE.
- out_carry = in_carry latched at accept, for all modes.
- in_flush=1: next state is IDLE and out_valid=0 on the next cycle. Any in-flight read is discarded.
  - Flush has priority over the in_valid accept and the out_ready handshake in the same cycle.
  - An instruction offered during a flush cycle is not accepted (in_ready is still 1 in IDLE, but the accept is suppressed).
- Register-file handling of R15 is external; this block reads whatever the port returns.

## Timing
- Reset (async, rst_n=0) values:
  - state=IDLE
  - in_ready=1
  - out_valid=0, rf_rd_en=0, rf_rd_addr=0
  - out_data=0, out_shift_value=0, out_op_select=0, out_carry=0
- Latency from accept cycle T to out_valid=1:
  - immediate: T+1
  - immediate shift: T+3
  - register shift: T+4
- Throughput: one instruction per (latency+1) cycles at best. in_ready=0 in every state except IDLE.
- Backpressure: OUT holds indefinitely while out_ready=0. Bundle values must not change.
- rf_rd_data is sampled exactly one cycle after the matching rf_rd_en cycle. No read is issued in IDLE, CAP or OUT.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous). No bundle is emitted.

## Test plan
- Immediate: in_instr=0x020004FF, in_carry=1 -> T+1: data=0x000000FF, op=3, shift=8, carry=1; no rf_rd_en.
- LSR #0 on R2: in_instr=0x00000022, R2=0x80000001 -> rf_rd_addr=2 at T+1; T+3: data=0x80000001, op=1, shift=32.
- ROR #0 on R3: in_instr=0x00000063 -> op=4 (RRX), shift=1, data=R3, carry=latched C.
- Register ASR: in_instr=0x00000551, R1=0xF0000000, R5=0x00000120 -> reads addr 1 then 5 on consecutive cycles; T+4: data=0xF0000000, op=2, shift=0x20.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> bundle constant and in_ready=0; out_ready=1 -> IDLE with in_ready=1 next cycle.
- Flush/reset: assert in_flush during RD_RS -> IDLE next cycle, no out_valid, next instruction processed correctly. Separately, pulse rst_n low during CAP -> all outputs at reset values immediately.

Source files
------------

// File: rtl/shifter_operand_fetch.sv
// shifter_operand_fetch
//   Decodes the shifter-operand field of a data-processing instruction and
//   gathers the operands for the barrel shifter. The operands are Rm and,
//   for register shifts, Rs. Both are read through one synchronous
//   register-file port. The result is a registered bundle that is held
//   stable until downstream accepts it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/ready    instruction handshake; in_instr bits [25] and [11:0] are used
//   in_carry          CPSR C flag, latched at accept
//   in_flush          synchronous flush back to IDLE, drops any in-flight work
//   rf_rd_en/addr     register-file read request (addr is 0 when not reading)
//   rf_rd_data        read data, valid the cycle after rf_rd_en
//   out_valid/ready   operand bundle handshake
//   out_data          value to shift
//   out_shift_value   shift amount
//   out_op_select     LSL=0, LSR=1, ASR=2, ROR=3, RRX=4
//   out_carry         carry-in for the shifter
module shifter_operand_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        in_carry,
  input  logic        in_flush,
  output logic        rf_rd_en,
  output logic [3:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_shift_value,
  output logic [2:0]  out_op_select,
  output logic        out_carry
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_RM = 3'd1,
    RD_RS = 3'd2,
    CAP   = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_RRX = 3'd4;

  state_t     state;
  logic       reg_shift;   // instr[4]: shift amount comes from Rs
  logic [3:0] rs_addr;     // instr[11:8], used for the second read

  // Only bit 25 and the low 12 bits of the instruction matter here.
  logic unused_instr;
  assign unused_instr = ^{in_instr[31:26], in_instr[24:12]};

  // Immediate-shift decode, taken straight from the offered instruction so
  // op/shift can be registered at accept time.
  logic [4:0] imm_amt;
  logic [1:0] imm_type;
  logic [2:0] imm_op;
  logic [7:0] imm_shift;

  assign imm_amt  = in_instr[11:7];
  assign imm_type = in_instr[6:5];

  always_comb begin
    imm_op    = {1'b0, imm_type};
    imm_shift = {3'b0, imm_amt};
    if (imm_amt == 5'd0) begin
      case (imm_type)
        2'b00: imm_shift = 8'd0;            // LSL #0: plain pass-through
        2'b01,
        2'b10: imm_shift = 8'd32;           // LSR/ASR #0 encode a shift of 32
        default: begin                      // ROR #0 encodes RRX
          imm_op    = OP_RRX;
          imm_shift = 8'd1;
        end
      endcase
    end
  end

  // State and request signals are both registered, so these are clean flop outputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      reg_shift       <= 1'b0;
      rs_addr         <= 4'd0;
      rf_rd_en        <= 1'b0;
      rf_rd_addr      <= 4'd0;
      out_data        <= 32'd0;
      out_shift_value <= 8'd0;
      out_op_select   <= OP_LSL;
      out_carry       <= 1'b0;
    end else if (in_flush) begin
      // Flush wins over any accept or handshake; any pending read data is ignored.
      state      <= IDLE;
      rf_rd_en   <= 1'b0;
      rf_rd_addr <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            reg_shift <= in_instr[4];
            rs_addr   <= in_instr[11:8];
            out_carry <= in_carry;
            if (in_instr[25]) begin
              // 8-bit immediate rotated right by twice the 4-bit rotate field
              out_data        <= {24'd0, in_instr[7:0]};
              out_op_select   <= OP_ROR;
              out_shift_value <= {3'b0, in_instr[11:8], 1'b0};
              state           <= OUT;
            end else begin
              rf_rd_en   <= 1'b1;
              rf_rd_addr <= in_instr[3:0];
              state      <= RD_RM;
              if (in_instr[4]) begin
                // Shift amount arrives later from Rs; the type is known now.
                out_op_select <= {1'b0, in_instr[6:5]};
              end else begin
                out_op_select   <= imm_op;
                out_shift_value <= imm_shift;
              end
            end
          end
        end

        RD_RM: begin
          if (reg_shift) begin
            rf_rd_en   <= 1'b1;
            rf_rd_addr <= rs_addr;
            state      <= RD_RS;
          end else begin
            rf_rd_en   <= 1'b0;
            rf_rd_addr <= 4'd0;
            state      <= CAP;
          end
        end

        RD_RS: begin
          out_data   <= rf_rd_data;    // Rm returned this cycle
          rf_rd_en   <= 1'b0;
          rf_rd_addr <= 4'd0;
          state      <= CAP;
        end

        CAP: begin
          if (reg_shift) out_shift_value <= rf_rd_data[7:0];  // Rs[7:0]
          else           out_data        <= rf_rd_data;       // Rm
          state <= OUT;
        end

        OUT: begin
          if (out_ready) state <= IDLE;
        end

        default: begin
          state      <= IDLE;
          rf_rd_en   <= 1'b0;
          rf_rd_addr <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_operand_fetch.sv
module tb_shifter_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        in_carry;
  logic        in_flush;
  logic        rf_rd_en;
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_shift_value;
  logic [2:0]  out_op_select;
  logic        out_carry;

  int checks = 0;
  int failures = 0;

  logic [31:0] rf [16];

  always #5 clk = ~clk;

  // Synchronous register-file read port model
  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= rf[rf_rd_addr];
  end

  shifter_operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_carry(in_carry), .in_flush(in_flush),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_shift_value(out_shift_value),
    .out_op_select(out_op_select), .out_carry(out_carry)
  );

  // Offer one instruction for one cycle; returns at the negedge after the accept edge.
  task automatic offer(input logic [31:0] instr, input logic c);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = instr;
    in_carry = c;
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (rf_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rf_rd_en got=%b exp=0", rf_rd_en); end
    checks++; if (rf_rd_addr !== 4'd0) begin failures++; $display("FAIL reset_rf_rd_addr got=%h exp=0", rf_rd_addr); end
    checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_shift_value !== 8'd0) begin failures++; $display("FAIL reset_shift got=%h exp=0", out_shift_value); end
    checks++; if (out_op_select !== 3'd0) begin failures++; $display("FAIL reset_op got=%h exp=0", out_op_select); end
    checks++; if (out_carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", out_carry); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: outputs at reset values");
  endtask

  task automatic test_immediate(input logic [31:0] instr, input logic c,
                                input logic [31:0] exp_data, input logic [7:0] exp_shift);
    out_ready = 1'b1;
    offer(instr, c);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL imm_valid got=%b exp=1", out_valid); end
    checks++; if (rf_rd_en !== 1'b0) begin failures++; $display("FAIL imm_no_read got=%b exp=0", rf_rd_en); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL imm_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_data !== exp_data) begin failures++; $display("FAIL imm_data got=%h exp=%h", out_data, exp_data); end
    checks++; if (out_op_select !== 3'd3) begin failures++; $display("FAIL imm_op got=%0d exp=3", out_op_select); end
    checks++; if (out_shift_value !== exp_shift) begin failures++; $display("FAIL imm_shift got=%0d exp=%0d", out_shift_value, exp_shift); end
    checks++; if (out_carry !== c) begin failures++; $display("FAIL imm_carry got=%b exp=%b", out_carry, c); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL imm_back_idle got=%b exp=1", in_ready); end
    $display("immediate instr=%h data=%h shift=%0d", instr, out_data, out_shift_value);
  endtask

  task automatic test_imm_shift(input logic [31:0] instr, input logic c, input logic [3:0] rm,
                                input logic [31:0] exp_data, input logic [2:0] exp_op,
                                input logic [7:0] exp_shift);
    out_ready = 1'b1;
    offer(instr, c);
    checks++; if (rf_rd_en !== 1'b1 || rf_rd_addr !== rm) begin failures++; $display("FAIL ishift_rd_rm got=%b/%h exp=1/%h", rf_rd_en, rf_rd_addr, rm); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ishift_early_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (rf_rd_en !== 1'b0 || rf_rd_addr !== 4'd0) begin failures++; $display("FAIL ishift_cap_noread got=%b/%h exp=0/0", rf_rd_en, rf_rd_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ishift_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== exp_data) begin failures++; $display("FAIL ishift_data got=%h exp=%h", out_data, exp_data); end
    checks++; if (out_op_select !== exp_op) begin failures++; $display("FAIL ishift_op got=%0d exp=%0d", out_op_select, exp_op); end
    checks++; if (out_shift_value !== exp_shift) begin failures++; $display("FAIL ishift_shift got=%0d exp=%0d", out_shift_value, exp_shift); end
    checks++; if (out_carry !== c) begin failures++; $display("FAIL ishift_carry got=%b exp=%b", out_carry, c); end
    @(negedge clk);
    $display("imm_shift instr=%h op=%0d shift=%0d data=%h", instr, exp_op, exp_shift, exp_data);
  endtask

  task automatic test_reg_shift();
    out_ready = 1'b1;
    offer(32'h00000551, 1'b0);
    checks++; if (rf_rd_en !== 1'b1 || rf_rd_addr !== 4'd1) begin failures++; $display("FAIL rshift_rd_rm got=%b/%h exp=1/1", rf_rd_en, rf_rd_addr); end
    @(negedge clk);
    checks++; if (rf_rd_en !== 1'b1 || rf_rd_addr !== 4'd5) begin failures++; $display("FAIL rshift_rd_rs got=%b/%h exp=1/5", rf_rd_en, rf_rd_addr); end
    @(negedge clk);
    checks++; if (rf_rd_en !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rshift_cap got=%b/%b exp=0/0", rf_rd_en, out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rshift_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'hF0000000) begin failures++; $display("FAIL rshift_data got=%h exp=f0000000", out_data); end
    checks++; if (out_op_select !== 3'd2) begin failures++; $display("FAIL rshift_op got=%0d exp=2", out_op_select); end
    checks++; if (out_shift_value !== 8'h20) begin failures++; $display("FAIL rshift_shift got=%h exp=20", out_shift_value); end
    @(negedge clk);
    $display("reg_shift instr=00000551 data=f0000000 op=2 shift=20");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(32'h02000A5C, 1'b1);   // 0x5C ror 20
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h0000005C ||
          out_shift_value !== 8'd20 || out_op_select !== 3'd3 || out_carry !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%b r=%b d=%h s=%0d op=%0d c=%b exp v=1 r=0 d=5c s=20 op=3 c=1",
                 i, out_valid, in_ready, out_data, out_shift_value, out_op_select, out_carry);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
    $display("backpressure: held 5 cycles then released");
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    offer(32'h00000551, 1'b0);
    @(negedge clk);               // now in RD_RS
    in_flush = 1'b1;
    @(negedge clk);
    in_flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || rf_rd_en !== 1'b0) begin failures++; $display("FAIL flush_idle got r=%b v=%b en=%b exp r=1 v=0 en=0", in_ready, out_valid, rf_rd_en); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_bundle cyc=%0d got=%b exp=0", i, out_valid); end
    end
    // An offer coinciding with flush is not accepted
    in_valid = 1'b1; in_instr = 32'h020000FF; in_flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_blocks_accept got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
    $display("flush: dropped in RD_RS and blocked accept");
    test_imm_shift(32'h00000282, 1'b0, 4'd2, 32'h80000001, 3'd0, 8'd5);  // LSL #5 R2
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    offer(32'h00000022, 1'b1);
    @(negedge clk);               // now in CAP
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || rf_rd_en !== 1'b0) begin failures++; $display("FAIL rst_mid_ctl got r=%b v=%b en=%b exp r=1 v=0 en=0", in_ready, out_valid, rf_rd_en); end
    checks++; if (out_op_select !== 3'd0 || out_shift_value !== 8'd0 || out_carry !== 1'b0 || out_data !== 32'd0) begin
      failures++; $display("FAIL rst_mid_bundle got op=%0d s=%0d c=%b d=%h exp all 0", out_op_select, out_shift_value, out_carry, out_data);
    end
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_no_bundle got=%b exp=0", out_valid); end
    rst_n = 1'b1;
    $display("reset mid-operation: outputs cleared asynchronously");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h11111111 * i;
    rf[1] = 32'hF0000000;
    rf[2] = 32'h80000001;
    rf[3] = 32'hDEADBEEF;
    rf[5] = 32'h00000120;
    rf_rd_data = 32'd0;
    in_valid = 1'b0; in_instr = 32'd0; in_carry = 1'b0; in_flush = 1'b0; out_ready = 1'b1;

    test_reset();
    test_immediate(32'h020004FF, 1'b1, 32'h000000FF, 8'd8);
    test_immediate(32'h020000AB, 1'b0, 32'h000000AB, 8'd0);
    test_imm_shift(32'h00000022, 1'b0, 4'd2, 32'h80000001, 3'd1, 8'd32);  // LSR #0
    test_imm_shift(32'h00000042, 1'b1, 4'd2, 32'h80000001, 3'd2, 8'd32);  // ASR #0
    test_imm_shift(32'h00000063, 1'b1, 4'd3, 32'hDEADBEEF, 3'd4, 8'd1);   // ROR #0 -> RRX
    test_imm_shift(32'h000003E3, 1'b0, 4'd3, 32'hDEADBEEF, 3'd3, 8'd7);   // ROR #7
    test_imm_shift(32'h00000002, 1'b0, 4'd2, 32'h80000001, 3'd0, 8'd0);   // LSL #0
    test_reg_shift();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_immediate(32'h02000F01, 1'b1, 32'h00000001, 8'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
